// File: rtl/uart_score_pkg.sv
// uart_score_pkg
// Shared definitions for the score-report UART transmitter: packet header and
// length, the character FSM state encoding and the packet byte builder.
// Optional feature macro: UART_SCORE_TX_PARITY_EN (adds an even-parity bit
// to every character; the PARITY state is only reached when it is defined).
package uart_score_pkg;

  localparam logic [7:0] PKT_HDR = 8'hA5;
  localparam int         PKT_LEN = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Byte idx of the report packet built from the snapshot values.
  // Byte 5 is the XOR checksum of bytes 0..4.
  function automatic logic [7:0] pkt_byte(
    input logic [2:0]  idx,
    input logic [13:0] score,
    input logic [9:0]  combo,
    input logic        finish
  );
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    logic [7:0] b4;
    b1 = {2'b00, score[13:8]};
    b2 = score[7:0];
    b3 = {finish, 5'b00000, combo[9:8]};
    b4 = combo[7:0];
    case (idx)
      3'd0:    pkt_byte = PKT_HDR;
      3'd1:    pkt_byte = b1;
      3'd2:    pkt_byte = b2;
      3'd3:    pkt_byte = b3;
      3'd4:    pkt_byte = b4;
      3'd5:    pkt_byte = PKT_HDR ^ b1 ^ b2 ^ b3 ^ b4;
      default: pkt_byte = 8'h00;
    endcase
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    even_parity = ^d;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte
// Serialises one byte as start(0), 8 data bits LSB first, [even parity],
// stop(1), each bit CLKS_PER_BIT uclk cycles long.
// Optional feature macro: UART_SCORE_TX_PARITY_EN.
// Ports:
//   uclk   in   clock
//   arst   in   asynchronous active-high reset (tx forced high)
//   load   in   take data; honoured only while ready is high
//   data   in   byte to send
//   ready  out  high in IDLE and on the last cycle of the stop bit, so a
//               new byte loaded then follows the stop bit with no gap
//   tx     out  registered serial line, idles high
module uart_tx_byte
  import uart_score_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       uclk,
  input  logic       arst,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_cnt_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic             bit_end_s;
`ifdef UART_SCORE_TX_PARITY_EN
  logic             parity_r;
`endif

  // Decode end-of-bit and the load window from the current state.
  always_comb begin
    bit_end_s = (baud_cnt_r == CNT_LAST);
    ready     = (state_r == IDLE) || ((state_r == STOP) && bit_end_s);
  end

  // Character framing FSM with baud counter and output shifter.
  always_ff @(posedge uclk or posedge arst) begin
    if (arst) begin
      state_r    <= IDLE;
      baud_cnt_r <= '0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
`ifdef UART_SCORE_TX_PARITY_EN
      parity_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          if (load) begin
            state_r  <= START;
            shift_r  <= data;
            tx_r     <= 1'b0;
`ifdef UART_SCORE_TX_PARITY_EN
            parity_r <= even_parity(data);
`endif
          end else begin
            tx_r <= 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r    <= DATA;
            baud_cnt_r <= '0;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              bit_cnt_r <= 3'd0;
`ifdef UART_SCORE_TX_PARITY_EN
              state_r   <= PARITY;
              tx_r      <= parity_r;
`else
              state_r   <= STOP;
              tx_r      <= 1'b1;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
`ifdef UART_SCORE_TX_PARITY_EN
        PARITY: begin
          if (bit_end_s) begin
            state_r    <= STOP;
            baud_cnt_r <= '0;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            // A byte loaded on the last stop cycle starts immediately.
            if (load) begin
              state_r  <= START;
              shift_r  <= data;
              tx_r     <= 1'b0;
`ifdef UART_SCORE_TX_PARITY_EN
              parity_r <= even_parity(data);
`endif
            end else begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= '0;
          bit_cnt_r  <= 3'd0;
          tx_r       <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_r;

endmodule

// File: rtl/uart_score_tx.sv
// uart_score_tx
// Sends a 6-byte game report (A5, score hi, score lo, finish/combo hi,
// combo lo, XOR checksum) over UART. Inputs are snapshotted when a send
// request is accepted; requests while busy are dropped.
// Optional feature macro: UART_SCORE_TX_PARITY_EN (even parity per char).
// Ports:
//   uclk    in   UART-domain clock
//   arst    in   asynchronous active-high reset, aborts a packet in flight
//   send    in   one-cycle transmit request
//   score   in   14-bit score
//   combo   in   10-bit combo
//   finish  in   song-finished flag
//   tx      out  serial line, idles high
//   busy    out  high while a packet is in flight
//   done    out  one-cycle pulse when the last stop bit ends
module uart_score_tx
  import uart_score_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        uclk,
  input  logic        arst,
  input  logic        send,
  input  logic [13:0] score,
  input  logic [9:0]  combo,
  input  logic        finish,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("uart_score_tx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  logic [13:0] score_r;
  logic [9:0]  combo_r;
  logic        finish_r;
  logic [2:0]  idx_r;
  logic        busy_r;
  logic        done_r;

  logic        accept_s;
  logic        next_s;
  logic        last_s;
  logic        load_s;
  logic [7:0]  load_data_s;
  logic        byte_ready_s;
  logic        byte_tx_s;

  // Packet sequencing decisions and the byte to hand to the serialiser.
  always_comb begin
    accept_s = send & ~busy_r;
    next_s   = busy_r & byte_ready_s & (idx_r != LAST_IDX);
    last_s   = busy_r & byte_ready_s & (idx_r == LAST_IDX);
    load_s   = accept_s | next_s;
    // The header is constant, so byte 0 needs no snapshot yet.
    if (accept_s) begin
      load_data_s = PKT_HDR;
    end else begin
      load_data_s = pkt_byte(idx_r + 3'd1, score_r, combo_r, finish_r);
    end
  end

  // Snapshot registers, byte index, busy flag and done pulse.
  always_ff @(posedge uclk or posedge arst) begin
    if (arst) begin
      score_r  <= 14'd0;
      combo_r  <= 10'd0;
      finish_r <= 1'b0;
      idx_r    <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        score_r  <= score;
        combo_r  <= combo;
        finish_r <= finish;
        idx_r    <= 3'd0;
        busy_r   <= 1'b1;
      end else if (next_s) begin
        idx_r <= idx_r + 3'd1;
      end else if (last_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .uclk  (uclk),
    .arst  (arst),
    .load  (load_s),
    .data  (load_data_s),
    .ready (byte_ready_s),
    .tx    (byte_tx_s)
  );

  assign tx   = byte_tx_s;
  assign busy = busy_r;
  assign done = done_r;

endmodule
